// File: rtl/id_pkg.sv
// -----------------------------------------------------------------------------
// id_pkg
// Shared definitions for the ID-stage hazard controller.
//   - Default widths and counts for the operand path
//   - fwd_src_t: one forwarding source record {we, waddr, wdata, data_ok}
//   - sat_inc32: saturating 32-bit increment used by the optional stall counter
// -----------------------------------------------------------------------------
package id_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int NREG_DEF      = 32;
    localparam int AW_DEF        = $clog2(NREG_DEF);
    localparam int NUM_RD_DEF    = 2;
    localparam int NUM_FWD_DEF   = 3;
    localparam int PAYLOAD_W_DEF = 64;

    // One forwarding source as seen from ID (default widths).
    typedef struct packed {
        logic                we;
        logic [AW_DEF-1:0]   waddr;
        logic [XLEN_DEF-1:0] wdata;
        logic                data_ok;
    } fwd_src_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// -----------------------------------------------------------------------------
// fwd_mux
// Operand resolution for a single read port.
// Picks the youngest (lowest index) forwarding source whose destination
// matches rd_addr; register 0 never forwards. A hit whose data is not yet
// final raises hazard when the operand is actually consumed.
//
// Ports:
//   rd_addr      in   AW            source register of this port
//   rd_need      in   1             operand is consumed
//   rf_rdata     in   XLEN          register-file read data
//   fwd_we       in   NUM_FWD       source writes a register
//   fwd_waddr    in   NUM_FWD*AW    destination per source
//   fwd_wdata    in   NUM_FWD*XLEN  result per source
//   fwd_data_ok  in   NUM_FWD       result per source is final
//   opnd         out  XLEN          resolved operand
//   hazard       out  1             youngest hit is not ready and is needed
// -----------------------------------------------------------------------------
module fwd_mux
    import id_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int AW      = AW_DEF,
    parameter int NUM_FWD = NUM_FWD_DEF
) (
    input  logic [AW-1:0]           rd_addr,
    input  logic                    rd_need,
    input  logic [XLEN-1:0]         rf_rdata,
    input  logic [NUM_FWD-1:0]      fwd_we,
    input  logic [NUM_FWD*AW-1:0]   fwd_waddr,
    input  logic [NUM_FWD*XLEN-1:0] fwd_wdata,
    input  logic [NUM_FWD-1:0]      fwd_data_ok,
    output logic [XLEN-1:0]         opnd,
    output logic                    hazard
);

    logic [NUM_FWD-1:0] w_match;
    logic               w_hit;
    logic               w_sel_ok;

    generate
        for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_match
            assign w_match[gi] = fwd_we[gi] && (fwd_waddr[gi*AW +: AW] == rd_addr);
        end
    endgenerate

    // Walk from oldest to youngest so the youngest match is the last writer.
    // The readiness flag travels with the selected source, so an older ready
    // match can never mask a younger load still in flight.
    always_comb begin
        w_hit    = 1'b0;
        w_sel_ok = 1'b0;
        opnd     = rf_rdata;
        for (int s = NUM_FWD - 1; s >= 0; s--) begin
            if (w_match[s]) begin
                w_hit    = 1'b1;
                w_sel_ok = fwd_data_ok[s];
                opnd     = fwd_wdata[s*XLEN +: XLEN];
            end
        end
        if (rd_addr == '0) begin
            w_hit = 1'b0;
            opnd  = rf_rdata;
        end
    end

    assign hazard = w_hit && !w_sel_ok && rd_need;

endmodule

// File: rtl/id_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// id_hazard_ctrl
// ID pipeline stage: one valid/payload register with valid-allowin handshake,
// per-port operand forwarding and load-use stall detection.
//
// Optional feature macro: ID_PERF_CNT_EN
//   defined   -> perf_stall_cnt port and saturating hazard-stall counter
//   undefined -> port and counter absent
//
// Ports:
//   clk            in   1             clock, all state on posedge
//   resetn         in   1             synchronous active-low reset
//   in_valid       in   1             IF holds a valid payload
//   in_allowin     out  1             stage accepts a payload this cycle
//   in_payload     in   PAYLOAD_W     payload from IF
//   flush          in   1             discard incoming payload, clear stage
//   out_valid      out  1             issuable payload presented to EXE
//   out_allowin    in   1             EXE accepts this cycle
//   out_payload    out  PAYLOAD_W     held payload
//   rd_addr        in   NUM_RD*AW     source register per port
//   rd_need        in   NUM_RD        operand consumed per port
//   rf_rdata       in   NUM_RD*XLEN   register-file data per port
//   fwd_we         in   NUM_FWD       forwarding source writes
//   fwd_waddr      in   NUM_FWD*AW    forwarding destination
//   fwd_wdata      in   NUM_FWD*XLEN  forwarding data
//   fwd_data_ok    in   NUM_FWD       forwarding data final
//   opnd           out  NUM_RD*XLEN   resolved operand per port
//   perf_stall_cnt out  32            stall cycle count (ID_PERF_CNT_EN)
//   stall          out  1             held payload blocked by data hazard
// -----------------------------------------------------------------------------
module id_hazard_ctrl
    import id_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int NREG      = NREG_DEF,
    parameter int NUM_RD    = NUM_RD_DEF,
    parameter int NUM_FWD   = NUM_FWD_DEF,
    parameter int PAYLOAD_W = PAYLOAD_W_DEF,
    localparam int AW       = $clog2(NREG)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    in_valid,
    output logic                    in_allowin,
    input  logic [PAYLOAD_W-1:0]    in_payload,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_allowin,
    output logic [PAYLOAD_W-1:0]    out_payload,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    input  logic [NUM_RD-1:0]       rd_need,
    input  logic [NUM_RD*XLEN-1:0]  rf_rdata,
    input  logic [NUM_FWD-1:0]      fwd_we,
    input  logic [NUM_FWD*AW-1:0]   fwd_waddr,
    input  logic [NUM_FWD*XLEN-1:0] fwd_wdata,
    input  logic [NUM_FWD-1:0]      fwd_data_ok,
    output logic [NUM_RD*XLEN-1:0]  opnd,
`ifdef ID_PERF_CNT_EN
    output logic [31:0]             perf_stall_cnt,
`endif
    output logic                    stall
);

    logic                 r_valid;
    logic [PAYLOAD_W-1:0] r_payload;
    logic [NUM_RD-1:0]    w_port_hazard;
    logic                 w_stall;
    logic                 w_in_allowin;
    logic                 w_accept;

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
            fwd_mux #(
                .XLEN    (XLEN),
                .AW      (AW),
                .NUM_FWD (NUM_FWD)
            ) u_fwd_mux (
                .rd_addr     (rd_addr[gi*AW +: AW]),
                .rd_need     (rd_need[gi]),
                .rf_rdata    (rf_rdata[gi*XLEN +: XLEN]),
                .fwd_we      (fwd_we),
                .fwd_waddr   (fwd_waddr),
                .fwd_wdata   (fwd_wdata),
                .fwd_data_ok (fwd_data_ok),
                .opnd        (opnd[gi*XLEN +: XLEN]),
                .hazard      (w_port_hazard[gi])
            );
        end
    endgenerate

    // Hazards only matter for a payload actually held in the stage.
    assign w_stall      = r_valid && (|w_port_hazard);
    assign w_in_allowin = !r_valid || (!w_stall && out_allowin);
    assign w_accept     = w_in_allowin && in_valid && !flush;

    assign in_allowin  = w_in_allowin;
    assign out_valid   = r_valid && !w_stall;
    assign out_payload = r_payload;
    assign stall       = w_stall;

    // A flush empties the stage next cycle even if the held payload is stuck;
    // it does not mask out_valid in the flush cycle itself.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid   <= 1'b0;
            r_payload <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_in_allowin) begin
                r_valid <= in_valid;
            end
            if (w_accept) begin
                r_payload <= in_payload;
            end
        end
    end

`ifdef ID_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_stall_cnt <= '0;
        end else if (w_stall) begin
            r_stall_cnt <= sat_inc32(r_stall_cnt);
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule
